// File: rtl/row_serializer.sv
// Row-to-pixel serializer: takes whole filtered rows over valid/ready and streams
// them out one pixel per clock with coordinates, using an active/holding row pair.
module row_serializer #(
  parameter int ROW   = 512,
  parameter int COL   = 512,
  parameter int width = 8,
  localparam int XW   = (ROW > 1) ? $clog2(ROW) : 1,
  localparam int YW   = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ROW*width-1:0] row_in,
  input  logic                 row_valid,
  output logic                 row_ready,
  output logic [width-1:0]     pix_out,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 pix_eol,
  output logic                 pix_eof,
  output logic                 frame_done
);

  typedef enum logic [1:0] {EMPTY, STREAM, FULL} state_t;

  state_t               state;
  logic [ROW*width-1:0] act;
  logic [ROW*width-1:0] hold;
  logic                 act_valid;
  logic                 hold_valid;
  logic                 accept;
  logic                 xfer;
  logic                 x_last;
  logic                 y_last;
  logic                 eol_xfer;

  always_comb begin
    act_valid  = (state != EMPTY);
    hold_valid = (state == FULL);
    row_ready  = ~hold_valid & ~RST;
    accept     = row_valid & row_ready;
    xfer       = act_valid & pix_ready;
    x_last     = (pix_x == XW'(ROW - 1));
    y_last     = (pix_y == YW'(COL - 1));
    eol_xfer   = xfer & x_last;
    pix_valid  = act_valid;
    pix_out    = act[ROW*width-1 -: width];
    pix_eol    = act_valid & x_last;
    pix_eof    = pix_eol & y_last;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= EMPTY;
      act        <= '0;
      hold       <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= eol_xfer & y_last;
      if (xfer)
        pix_x <= x_last ? '0 : pix_x + 1'b1;
      if (eol_xfer)
        pix_y <= y_last ? '0 : pix_y + 1'b1;

      case (state)
        EMPTY: begin
          if (accept) begin
            act   <= row_in;
            state <= STREAM;
          end
        end
        STREAM: begin
          // A row arriving on the last-pixel transfer goes straight into act so the stream has no bubble.
          if (eol_xfer) begin
            if (accept)
              act <= row_in;
            else
              state <= EMPTY;
          end else begin
            if (xfer)
              act <= act << width;
            if (accept) begin
              hold  <= row_in;
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (eol_xfer) begin
            act   <= hold;
            state <= STREAM;
          end else if (xfer) begin
            act <= act << width;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_row_serializer.sv
// Scoreboard bench for row_serializer (ROW=4, COL=3, width=8): the driver queues the
// expected pixels of each accepted row, an independent monitor pops and checks them.
module tb_row_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] row_in = '0;
  logic        row_valid = 1'b0;
  logic        row_ready;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [1:0]  pix_x;
  logic [1:0]  pix_y;
  logic        pix_eol;
  logic        pix_eof;
  logic        frame_done;

  row_serializer #(.ROW(4), .COL(3), .width(8)) dut (
    .CLK(CLK), .RST(RST), .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x),
    .pix_y(pix_y), .pix_eol(pix_eol), .pix_eof(pix_eof), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] pix;
    logic [1:0] x;
    logic [1:0] y;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   rows_sent = 0;
  int   fd_count = 0;
  bit   ready_low_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected pixels of one accepted row; row index in frame comes from the bench's own row count.
  task automatic push_row(input logic [31:0] r);
    exp_t e;
    logic [1:0] y;
    y = 2'(rows_sent % 3);
    for (int i = 0; i < 4; i++) begin
      e.pix = r[(3-i)*8 +: 8];
      e.x   = 2'(i);
      e.y   = y;
      e.eol = (i == 3);
      e.eof = (i == 3) && (y == 2'd2);
      q.push_back(e);
    end
    rows_sent++;
  endtask

  // Called just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send_row(input logic [31:0] r);
    int n;
    row_in    = r;
    row_valid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!row_ready && n < 100) begin
      ready_low_seen = 1;
      n++;
      @(negedge CLK);
    end
    if (!row_ready) begin
      chk("row_accept_timeout", 32'(row_ready), 32'd1);
    end else begin
      @(posedge CLK);
      #1;
      push_row(r);
    end
    row_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    q.delete();
    rows_sent = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Monitor: per-cycle checks of valid, frame_done, stall stability and transferred pixels.
  initial begin
    exp_t e;
    bit   prev_stall;
    bit   exp_fd;
    bit   next_fd;
    logic [7:0] s_pix;
    logic [1:0] s_x, s_y;
    logic s_eol, s_eof;
    prev_stall = 0;
    exp_fd = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_stall = 0;
        exp_fd = 0;
        continue;
      end
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) fd_count++;
      chk("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
      if (prev_stall) begin
        chk("stall_pix", 32'(pix_out), 32'(s_pix));
        chk("stall_x", 32'(pix_x), 32'(s_x));
        chk("stall_y", 32'(pix_y), 32'(s_y));
        chk("stall_eol", 32'(pix_eol), 32'(s_eol));
        chk("stall_eof", 32'(pix_eof), 32'(s_eof));
      end
      next_fd = 0;
      if (pix_valid && pix_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_pixel", 32'(pix_out), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("pix_out", 32'(pix_out), 32'(e.pix));
          chk("pix_x", 32'(pix_x), 32'(e.x));
          chk("pix_y", 32'(pix_y), 32'(e.y));
          chk("pix_eol", 32'(pix_eol), 32'(e.eol));
          chk("pix_eof", 32'(pix_eof), 32'(e.eof));
          next_fd = e.eof;
        end
      end
      exp_fd = next_fd;
      prev_stall = pix_valid && !pix_ready;
      s_pix = pix_out; s_x = pix_x; s_y = pix_y; s_eol = pix_eol; s_eof = pix_eof;
    end
  end

  initial begin
    int fd0;
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      row_in    = $urandom;
      row_valid = 1'($urandom_range(0, 1));
      pix_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("rst_outputs", {pix_out, 2'b0, pix_x, 2'b0, pix_y, 4'b0, row_ready, pix_valid,
                          pix_eol, pix_eof, 3'b0, frame_done}, 32'd0);
      @(posedge CLK);
      #1;
    end
    row_valid = 1'b0;
    pix_ready = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_row_ready", 32'(row_ready), 32'd1);
    chk("post_rst_pix_valid", 32'(pix_valid), 32'd0);
    @(posedge CLK);
    #1;

    // Single row
    pix_ready = 1'b1;
    send_row(32'h11223344);
    wait_drain();

    // Backpressure while 0x22 is presented
    send_row(32'h11223344);
    @(posedge CLK);
    #1;
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_pix", 32'(pix_out), 32'h22);
      chk("bp_x", 32'(pix_x), 32'd1);
      chk("bp_valid", 32'(pix_valid), 32'd1);
    end
    @(posedge CLK);
    #1;
    pix_ready = 1'b1;
    wait_drain();

    // Full frame back-to-back, then first row of the next frame
    do_reset();
    ready_low_seen = 0;
    fd0 = fd_count;
    send_row(32'hA0A1A2A3);
    send_row(32'hB0B1B2B3);
    send_row(32'hC0C1C2C3);
    send_row(32'hD0D1D2D3);
    wait_drain();
    chk("frame_row_ready_low", 32'(ready_low_seen), 32'd1);
    chk("frame_done_pulses", 32'(fd_count - fd0), 32'd1);

    // Reset mid-row with hold full
    pix_ready = 1'b0;
    send_row(32'h11223344);
    send_row(32'h99AABBCC);
    @(negedge CLK);
    chk("mid_row_ready_full", 32'(row_ready), 32'd0);
    @(posedge CLK);
    #1;
    pix_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    q.delete();
    rows_sent = 0;
    #1;
    chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_row_ready", 32'(row_ready), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    send_row(32'h55667788);
    @(negedge CLK);
    chk("post_mid_rst_x", 32'(pix_x), 32'd0);
    chk("post_mid_rst_pix", 32'(pix_out), 32'h55);
    wait_drain();

    // Accept coinciding with the last-pixel transfer, hold empty
    send_row(32'h01020304);
    repeat (3) @(posedge CLK);
    #1;
    send_row(32'hE1E2E3E4);
    @(negedge CLK);
    chk("simul_valid", 32'(pix_valid), 32'd1);
    chk("simul_x", 32'(pix_x), 32'd0);
    chk("simul_pix", 32'(pix_out), 32'hE1);
    chk("simul_row_ready", 32'(row_ready), 32'd1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/row_serializer.md
Name: row_serializer

Overview:
- Output-side counterpart of the median filter's 3-row window FSM. That FSM consumes whole image rows; this block emits them.
- Accepts full filtered rows (ROW pixels, `width` bits each) from the median stage through a valid/ready handshake.
- Streams the pixels out one per clock with pixel/row coordinates and end-of-line/end-of-frame flags, toward the frame writer.
- Double-buffered: the next row can be accepted while the current row is still shifting out, so a frame streams with no bubbles.

Parameters:
ROW, 512, pixels per row.
COL, 512, rows per frame.
width, 8, bits per pixel.
(derived) XW = $clog2(ROW), YW = $clog2(COL): widths of the coordinate counters.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  reset, asynchronous, active-high.
row_in  input  ROW*width  filtered row. Pixel i is row_in[(ROW-i)*width-1 -: width], i.e. pixel 0 is the MSB slice.
row_valid  input  1  row_in holds a row.
row_ready  output  1  block can accept a row this cycle.
pix_out  output  width  current pixel.
pix_valid  output  1  pix_out is valid.
pix_ready  input  1  downstream accepts pix_out this cycle.
pix_x  output  XW  column index of pix_out, 0..ROW-1.
pix_y  output  YW  row index of pix_out, 0..COL-1.
pix_eol  output  1  pix_out is the last pixel of its row (pix_x == ROW-1).
pix_eof  output  1  pix_out is the last pixel of the frame (pix_eol and pix_y == COL-1).
frame_done  output  1  single-cycle pulse after the last pixel of the frame is transferred.

Behaviour:
- Storage: an active shift register (act, with act_valid) and a holding register (hold, with hold_valid).
- Reset:
  - While RST is high, all outputs are 0, including row_ready.
  - All registers and counters are cleared; act_valid and hold_valid are 0.
  - Reset asserted mid-row flushes both buffers; the partially sent row is discarded.
- Handshake terms:
  - Row accept: row_valid & row_ready, with row_ready = ~hold_valid & ~RST.
  - Pixel transfer: pix_valid & pix_ready, with pix_valid = act_valid.
  - pix_out, pix_x, pix_y, pix_eol and pix_eof hold stable while pix_valid & ~pix_ready.
- Row accept routing:
  - If act is empty, or act is transferring its last pixel this cycle, and hold is empty: load the row into act.
  - Otherwise: load the row into hold.
  - Latency: the first pixel appears (pix_valid=1) the cycle after acceptance.
- Pixel transfer:
  - Shift act left by `width` and increment pix_x.
  - On the pix_eol transfer, pix_x wraps to 0.
  - On that same transfer, act reloads from hold if hold_valid (clearing hold_valid); otherwise act_valid goes to 0.
  - Back-to-back rows produce no idle cycle between the last pixel of one row and the first pixel of the next.
- Simultaneous events:
  - Case: hold empty, last-pixel transfer in progress, and a new row accepted. The new row goes straight into act, pix_valid stays 1, no bubble.
  - Case: hold full. row_ready is 0, so no accept can occur.
- Row counter:
  - pix_y increments on each pix_eol transfer.
  - On the pix_eof transfer, pix_y wraps to 0 and frame_done pulses high for exactly the next cycle.
  - The block then continues accepting rows for the next frame; there is no sleep state.
- FSM (reported per row, derived from act_valid/hold_valid):
  - EMPTY: act=0, hold=0.
  - STREAM: act=1, hold=0.
  - FULL: act=1, hold=1.
  - Transitions occur only through the accept and transfer events above.
  - FULL→STREAM on the eol transfer.
  - STREAM→EMPTY on the eol transfer with no accept.
  - STREAM→FULL on an accept without an eol transfer.
- Arithmetic: counters wrap at ROW-1 and COL-1 exactly; they never pass through unused codes when ROW or COL is not a power of two.

Test Plan (ROW=4, COL=3, width=8):
- Reset: hold RST=1 for 3 cycles with random inputs → every output 0, row_ready 0. Release RST → row_ready=1, pix_valid=0.
- Single row: row_in=0x11223344 accepted at cycle t, pix_ready=1.
  - pix_out = 11,22,33,44 at t+1..t+4, with pix_x 0..3 and pix_y 0.
  - pix_eol only with 0x44; pix_valid=0 at t+5.
- Backpressure: same row, pix_ready=0 for 3 cycles while 0x22 is presented → pix_out, pix_x=1 and pix_valid stay constant. Resume → 33,44 follow; nothing dropped or duplicated.
- Full frame back-to-back: rows 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3 offered continuously with pix_ready=1.
  - row_ready drops to 0 while act and hold are both full.
  - 12 consecutive pixels, no gaps; pix_y steps 0,1,2.
  - pix_eof on 0xC3; frame_done high exactly one cycle after it; next row gets pix_y=0.
- Reset mid-row: assert RST after 0x22 is transferred with hold full → pix_valid=0 immediately. After release, a new row 0x55667788 starts at pix_x=0, pix_y=0, and no old data appears.
- Simultaneous accept and eol: hold empty, row accepted in the same cycle 0x44 transfers → the next cycle shows the new row's pixel 0 with pix_valid=1 and pix_x=0.
